wb_bram_32x512: RTL and testbench



---
 rtl/wb_bram_pkg.sv | 15 +
 rtl/wb_bram_32x512_if.sv | 24 ++
 rtl/ram_sp_be_512x32.sv | 30 +++
 rtl/wb_bram_32x512.sv | 57 +++++
 tb/tb_wb_bram_32x512.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/wb_bram_pkg.sv
// Shared geometry and types for the Wishbone 512x32 block RAM slave.
package wb_bram_pkg;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned AW     = 11;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef logic [AW-1:0]     addr_t;
  typedef logic [IDX_W-1:0]  word_idx_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LANES-1:0]  lane_mask_t;

endpackage

// File: rtl/wb_bram_32x512_if.sv
// Wishbone classic bus bundle between a master and the block RAM slave.
interface wb_bram_32x512_if;
  import wb_bram_pkg::*;

  addr_t      addr_i;
  word_t      data_i;
  logic       we_i;
  logic       cyc_i;
  logic       stb_i;
  lane_mask_t sel_i;
  logic       ack_o;
  word_t      data_o;

  modport master (
    output addr_i, data_i, we_i, cyc_i, stb_i, sel_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, we_i, cyc_i, stb_i, sel_i,
    output ack_o, data_o
  );

endinterface

// File: rtl/ram_sp_be_512x32.sv
// Single-port synchronous RAM, per-byte write enables, write-first registered output.
module ram_sp_be_512x32
  import wb_bram_pkg::*;
(
  input  logic       clk_i,
  input  logic       en,
  input  lane_mask_t we,
  input  word_idx_t  addr,
  input  word_t      wdata,
  output word_t      rdata
);

  word_t mem [DEPTH];

  // Per-lane write-first form is the pattern both Xilinx and Altera map to
  // a byte-enabled block RAM; rdata holds while en is low.
  always_ff @(posedge clk_i) begin
    if (en) begin
      for (int unsigned n = 0; n < LANES; n++) begin
        if (we[n]) begin
          mem[addr][8*n +: 8] <= wdata[8*n +: 8];
          rdata[8*n +: 8]     <= wdata[8*n +: 8];
        end else begin
          rdata[8*n +: 8]     <= mem[addr][8*n +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/wb_bram_32x512.sv
// Wishbone classic slave around a 512x32 byte-enabled block RAM: one wait state,
// single-cycle ack pulse, reset release synchronized with two flops.
module wb_bram_32x512
  import wb_bram_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  wb_bram_32x512_if.slave   wb
);

  logic [1:0] rst_sync;
  logic       ready;
  logic       req;
  logic       ack_q;
  logic       valid_q;
  lane_mask_t we_lanes;
  word_t      ram_q;
  logic [1:0] unused_addr_lsb;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign ready = rst_sync[1];

  always_comb begin
    req      = ready & wb.cyc_i & wb.stb_i & ~ack_q;
    we_lanes = (req & wb.we_i) ? wb.sel_i : '0;
  end

  // The RAM output register cannot carry an async reset and still infer a
  // block RAM, so valid_q masks data_o to zero until the first access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ack_q <= req;
      if (req) valid_q <= 1'b1;
    end
  end

  ram_sp_be_512x32 u_ram (
    .clk_i (clk_i),
    .en    (req),
    .we    (we_lanes),
    .addr  (wb.addr_i[AW-1:2]),
    .wdata (wb.data_i),
    .rdata (ram_q)
  );

  assign wb.ack_o         = ack_q;
  assign wb.data_o        = valid_q ? ram_q : '0;
  assign unused_addr_lsb  = wb.addr_i[1:0];

endmodule

// File: tb/tb_wb_bram_32x512.sv
// Directed self-checking bench for wb_bram_32x512.
module tb_wb_bram_32x512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  wb_bram_32x512_if bus ();

  wb_bram_32x512 dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .wb      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    bus.we_i   = 1'b0;
    bus.sel_i  = 4'h0;
    bus.addr_i = '0;
    bus.data_i = '0;
  endtask

  // One transfer: ack and data one cycle after the request edge, then ack
  // must drop at the next edge even with the strobe still asserted.
  task automatic xfer(input string tag, input logic we, input logic [10:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      input logic [31:0] exp);
    @(negedge clk);
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    bus.we_i   = we;
    bus.addr_i = addr;
    bus.data_i = wdata;
    bus.sel_i  = sel;
    @(posedge clk); #1;
    check({tag, "_ack"}, {31'b0, bus.ack_o}, 32'h1);
    check({tag, "_data"}, bus.data_o, exp);
    @(posedge clk); #1;
    check({tag, "_ackpulse"}, {31'b0, bus.ack_o}, 32'h0);
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    int         n_ack;
    logic       prev_ack;
    logic [31:0] exp_b2b;

    bus_idle();
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    #1;
    check("rst_ack", {31'b0, bus.ack_o}, 32'h0);
    check("rst_data", bus.data_o, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_idle();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    xfer("wr040", 1'b1, 11'h040, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF);
    xfer("rd040", 1'b0, 11'h040, 32'h0,        4'h0, 32'hDEADBEEF);
    xfer("wrlane", 1'b1, 11'h040, 32'h11223344, 4'b0101, 32'hDE22BE44);
    xfer("rdlane", 1'b0, 11'h040, 32'h0,        4'hF, 32'hDE22BE44);
    xfer("wrsel0", 1'b1, 11'h040, 32'hFFFFFFFF, 4'h0, 32'hDE22BE44);
    xfer("rdsel0", 1'b0, 11'h040, 32'h0,        4'h0, 32'hDE22BE44);

    xfer("wr044", 1'b1, 11'h044, 32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5);
    xfer("rd045", 1'b0, 11'h045, 32'h0, 4'h0, 32'hA5A5A5A5);
    xfer("rd046", 1'b0, 11'h046, 32'h0, 4'h0, 32'hA5A5A5A5);
    xfer("rd047", 1'b0, 11'h047, 32'h0, 4'h0, 32'hA5A5A5A5);
    xfer("rd040b", 1'b0, 11'h040, 32'h0, 4'h0, 32'hDE22BE44);

    xfer("wr000", 1'b1, 11'h000, 32'h12345678, 4'hF, 32'h12345678);
    xfer("wr7fc", 1'b1, 11'h7FC, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D);

    // Back-to-back reads with the strobe held for 6 edges.
    n_ack    = 0;
    prev_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.cyc_i  = 1'b1;
      bus.stb_i  = 1'b1;
      bus.we_i   = 1'b0;
      bus.addr_i = (n_ack % 2 == 0) ? 11'h000 : 11'h7FC;
      @(posedge clk); #1;
      if (bus.ack_o === 1'b1) begin
        exp_b2b = (n_ack % 2 == 0) ? 32'h12345678 : 32'hCAFEF00D;
        check("b2b_data", bus.data_o, exp_b2b);
        n_ack++;
      end
      check("b2b_noconsec", {31'b0, prev_ack & bus.ack_o}, 32'h0);
      prev_ack = bus.ack_o;
    end
    @(negedge clk);
    bus_idle();
    check("b2b_count", n_ack, 32'd3);
    xfer("rd7fc", 1'b0, 11'h7FC, 32'h0, 4'h0, 32'hCAFEF00D);

    // Write-shaped bus activity with the strobe low must be ignored.
    @(negedge clk);
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b0;
    bus.we_i   = 1'b1;
    bus.addr_i = 11'h040;
    bus.data_i = 32'h0;
    bus.sel_i  = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_ack", {31'b0, bus.ack_o}, 32'h0);
      check("idle_data", bus.data_o, 32'hCAFEF00D);
    end
    @(negedge clk);
    bus_idle();
    xfer("rdidle", 1'b0, 11'h040, 32'h0, 4'h0, 32'hDE22BE44);

    // Reset asserted while ack is high, with a write held on the bus.
    @(negedge clk);
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = 11'h044;
    @(posedge clk); #1;
    check("mid_ack", {31'b0, bus.ack_o}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack", {31'b0, bus.ack_o}, 32'h0);
    check("mid_rst_data", bus.data_o, 32'h0);
    bus.we_i   = 1'b1;
    bus.addr_i = 11'h040;
    bus.data_i = 32'h0;
    bus.sel_i  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("in_rst_ack", {31'b0, bus.ack_o}, 32'h0);
    end
    @(negedge clk);
    bus.we_i = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check("rel_edge1", {31'b0, bus.ack_o}, 32'h0);
    @(posedge clk); #1;
    check("rel_edge2", {31'b0, bus.ack_o}, 32'h0);
    @(posedge clk); #1;
    check("rel_edge3", {31'b0, bus.ack_o}, 32'h1);
    check("rel_data", bus.data_o, 32'hDE22BE44);
    @(negedge clk);
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
